// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp -- multi-port integer register file with pending-write scoreboard
//
// Purpose:
//   Architectural register file for a dual-writeback pipeline. It has NRD
//   asynchronous read ports and two write ports. Same-cycle writes are forwarded
//   to the read ports. A per-register pending bit records which registers still
//   wait for a writeback. A registered population count of those bits, plus a
//   "full" flag, drives the issue stage.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous active-high reset (clears data and scoreboard)
//   rd_addr        NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data        NRD packed read data, port k at [k*XLEN +: XLEN]
//   rd_pending     per-port: addressed register still awaits a writeback
//   we0/waddr0/wdata0   write port 0
//   we1/waddr1/wdata1   write port 1 (wins over port 0 on the same address)
//   issue_valid    an instruction with destination issue_rd is issuing
//   issue_rd       destination register of the issuing instruction
//   pending_count  registered number of pending registers (0..NREG-1)
//   sb_full        registered; 1 when pending_count == NREG-1
// -----------------------------------------------------------------------------
module reg_file_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_pending,
  input  logic                 we0,
  input  logic [AW-1:0]        waddr0,
  input  logic [XLEN-1:0]      wdata0,
  input  logic                 we1,
  input  logic [AW-1:0]        waddr1,
  input  logic [XLEN-1:0]      wdata1,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic [AW:0]          pending_count,
  output logic                 sb_full
);

  localparam int CW = AW + 1;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [CW-1:0]   count_nxt;

  // Register 0 is hard-wired, so writes aimed at it are dropped here.
  logic wr0_ok, wr1_ok;
  assign wr0_ok = we0 && (waddr0 != '0);
  assign wr1_ok = we1 && (waddr1 != '0);

  // ---------------------------------------------------------------------------
  // Data storage
  // ---------------------------------------------------------------------------
  // NOTE: the whole array is cleared on reset because reads after reset must
  // return 0 and not X. For that reason this array is built from flops and not
  // from a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Port 1 is
      // assigned after port 0, so port 1's data is stored when both ports
      // target the same address.
      if (wr0_ok) regs[waddr0] <= wdata0;
      if (wr1_ok) regs[waddr1] <= wdata1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next state: an issue wins over a writeback to the same register,
  // because the newly issued producer is the one still outstanding.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_nxt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (issue_valid && (issue_rd == AW'(r)))
        pending_nxt[r] = 1'b1;
      else if ((wr0_ok && (waddr0 == AW'(r))) || (wr1_ok && (waddr1 == AW'(r))))
        pending_nxt[r] = 1'b0;
      else
        pending_nxt[r] = pending[r];
    end
  end

  // The count is a population count of the next-state vector and is never kept
  // incrementally. Redundant issues or writebacks therefore cannot skew it.
  always_comb begin
    count_nxt = '0;
    for (int r = 1; r < NREG; r++) count_nxt = count_nxt + CW'(pending_nxt[r]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending       <= '0;
      pending_count <= '0;
      sb_full       <= 1'b0;
    end else begin
      pending       <= pending_nxt;
      pending_count <= count_nxt;
      sb_full       <= (count_nxt == CW'(NREG - 1));
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with write-through forwarding (priority: x0, port 1, port 0, array)
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit0, hit1;
    logic [XLEN-1:0] data;

    assign addr = rd_addr[k*AW +: AW];
    assign hit0 = we0 && (waddr0 == addr);
    assign hit1 = we1 && (waddr1 == addr);

    // NOTE: every branch of this if/else chain assigns data, so the block
    // stays purely combinational and no latch is inferred.
    always_comb begin
      if (addr == '0)  data = '0;
      else if (hit1)   data = wdata1;
      else if (hit0)   data = wdata0;
      else             data = regs[addr];
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    // A same-cycle writeback clears the dependency at once. A same-cycle issue
    // is not shown here on purpose.
    assign rd_pending[k] = (addr != '0) && pending[addr] && !hit0 && !hit1;
  end

endmodule
